// File: rtl/fp_norm_pkg.sv
// Shared constants for the floating-point normalize/round sequencer.
// State encodings, field widths and flag bit positions.
package fp_norm_pkg;

   localparam int BIAS    = 127;
   localparam int EXP_MAX = 255;
   localparam int MANT_W  = 25;
   localparam int EXP_W   = 10;
   localparam int LZC_W   = 5;

   localparam int F_ZERO = 3;
   localparam int F_OVF  = 2;
   localparam int F_UNF  = 1;
   localparam int F_INX  = 0;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_DETECT = 3'd1;
   localparam state_t S_SHIFT  = 3'd2;
   localparam state_t S_ROUND  = 3'd3;
   localparam state_t S_HOLD   = 3'd4;

   localparam logic signed [EXP_W-1:0] EXP_HI = 10'(EXP_MAX);
   localparam logic signed [EXP_W-1:0] EXP_LO = 10'sd0;

endpackage

// File: rtl/fp_lzc25.sv
// Leading-zero counter for the 25-bit raw mantissa.
// An all-zero input reports a count of 25 and raises zero.
module fp_lzc25
   import fp_norm_pkg::*;
(
   input  logic [MANT_W-1:0] value,
   output logic [LZC_W-1:0]  count,
   output logic              zero
);

   always_comb begin
      count = LZC_W'(MANT_W);
      // Ascending scan so the highest set bit wins.
      for (int i = 0; i < MANT_W; i++) begin
         if (value[i]) count = LZC_W'(MANT_W - 1 - i);
      end
   end

   assign zero = (value == '0);

endmodule

// File: rtl/fp_norm_seq.sv
// Multi-cycle normalize, round-to-nearest-even and pack to IEEE754 single.
// One transaction in flight; result held until the downstream handshake.
module fp_norm_seq
   import fp_norm_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [9:0]  in_exp,
   input  logic [24:0] in_mant,
   input  logic [1:0]  in_gs,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [3:0]  out_flags
);

   state_t                   state;
   logic                     sign_q;
   logic signed [EXP_W-1:0]  exp_q;
   logic [MANT_W-1:0]        mant_q;
   logic                     guard_q;
   logic                     sticky_q;
   logic                     zero_q;
   logic                     inexact_q;
   logic [LZC_W-1:0]         lz_q;

   logic [LZC_W-1:0]         lz_cnt;
   logic                     lz_zero;
   logic                     is_zero;
   logic [LZC_W-1:0]         shamt;
   logic                     round_up;
   logic [MANT_W-1:0]        rnd;
   logic [31:0]              pack_result;
   logic [3:0]               pack_flags;

   fp_lzc25 u_lzc (
      .value (mant_q),
      .count (lz_cnt),
      .zero  (lz_zero)
   );

   assign in_ready = (state == S_IDLE) && !rst;
   assign is_zero  = lz_zero & ~guard_q & ~sticky_q;
   assign shamt    = lz_q - 5'd1;
   assign round_up = guard_q & (sticky_q | mant_q[0]);
   assign rnd      = mant_q + {{(MANT_W-1){1'b0}}, round_up};

   always_comb begin
      pack_result = {sign_q, 31'b0};
      pack_flags  = '0;
      if (zero_q) begin
         pack_flags[F_ZERO] = 1'b1;
      end else if (exp_q >= EXP_HI) begin
         pack_result        = {sign_q, 8'hFF, 23'b0};
         pack_flags[F_OVF]  = 1'b1;
         pack_flags[F_INX]  = 1'b1;
      end else if (exp_q <= EXP_LO) begin
         pack_flags[F_UNF]  = 1'b1;
         pack_flags[F_INX]  = 1'b1;
      end else begin
         pack_result        = {sign_q, exp_q[7:0], mant_q[22:0]};
         pack_flags[F_INX]  = inexact_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (in_valid) begin
                  sign_q   <= in_sign;
                  exp_q    <= in_exp;
                  mant_q   <= in_mant;
                  guard_q  <= in_gs[1];
                  sticky_q <= in_gs[0];
                  state    <= S_DETECT;
               end
            end
            S_DETECT: begin
               lz_q   <= lz_cnt;
               zero_q <= is_zero;
               state  <= is_zero ? S_HOLD : S_SHIFT;
            end
            S_SHIFT: begin
               if (lz_q == 5'd0) begin
                  mant_q   <= mant_q >> 1;
                  exp_q    <= exp_q + 10'sd1;
                  guard_q  <= mant_q[0];
                  sticky_q <= guard_q | sticky_q;
               end else begin
                  // Guard fills the vacated bit0 only on a real left shift.
                  mant_q <= (mant_q << shamt)
                          | {{(MANT_W-1){1'b0}}, guard_q & (lz_q >= 5'd2)};
                  exp_q  <= exp_q - EXP_W'(shamt);
                  if (lz_q >= 5'd2) guard_q <= 1'b0;
               end
               state <= S_ROUND;
            end
            S_ROUND: begin
               inexact_q <= guard_q | sticky_q;
               if (rnd[MANT_W-1]) begin
                  mant_q <= rnd >> 1;
                  exp_q  <= exp_q + 10'sd1;
               end else begin
                  mant_q <= rnd;
               end
               state <= S_HOLD;
            end
            S_HOLD: begin
               // First HOLD cycle packs; later cycles wait for the consumer.
               if (!out_valid) begin
                  out_valid  <= 1'b1;
                  out_result <= pack_result;
                  out_flags  <= pack_flags;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_norm_seq.sv
// Directed bench for fp_norm_seq with a result scoreboard.
// Expected values are hand-derived constants queued at drive time.
module tb_fp_norm_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [24:0] in_mant;
   logic [1:0]  in_gs;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_flags;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   fp_norm_seq dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sign    (in_sign),
      .in_exp     (in_exp),
      .in_mant    (in_mant),
      .in_gs      (in_gs),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] req);
      total++;
      assert (obs === req) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, req);
   endtask

   task automatic run_txn(input logic s, input logic [9:0] e,
                          input logic [24:0] m, input logic [1:0] gs,
                          input logic [31:0] r, input logic [3:0] f,
                          input int lat, input int stall, input string tag);
      exp_t x;
      exp_t got;
      int   n;
      logic [31:0] held_r;
      logic [3:0]  held_f;
      x.res = r;
      x.flg = f;
      x.tag = tag;
      sb.push_back(x);
      @(negedge clk);
      out_ready = (stall == 0);
      in_valid  = 1'b1;
      in_sign   = s;
      in_exp    = e;
      in_mant   = m;
      in_gs     = gs;
      #1;
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sign  = ~s;
      in_exp   = 10'h155;
      in_mant  = 25'h1ABCDEF;
      in_gs    = 2'b11;
      n = 0;
      while (!out_valid && n < 8) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(lat));
      if (sb.size() > 0) begin
         got = sb.pop_front();
         chk({got.tag, "_result"}, out_result, got.res);
         chk({got.tag, "_flags"}, 32'(out_flags), 32'(got.flg));
      end
      held_r = out_result;
      held_f = out_flags;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_stall_result"}, out_result, held_r);
         chk({tag, "_stall_flags"}, 32'(out_flags), 32'(held_f));
         chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_retire_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_retire_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = '0;
      in_mant   = '0;
      in_gs     = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_flags", 32'(out_flags), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      run_txn(1'b0, 10'd127, 25'h0800000, 2'b00, 32'h3F800000, 4'b0000, 4, 0, "one");
      run_txn(1'b0, 10'd127, 25'h1800000, 2'b00, 32'h40400000, 4'b0000, 4, 0, "carry_in");
      run_txn(1'b0, 10'd150, 25'h0000001, 2'b00, 32'h3F800000, 4'b0000, 4, 0, "lz24");
      run_txn(1'b0, 10'd127, 25'h0FFFFFF, 2'b10, 32'h40000000, 4'b0001, 4, 0, "rnd_carry");
      run_txn(1'b1, 10'd254, 25'h1000000, 2'b00, 32'hFF800000, 4'b0101, 4, 0, "ovf");
      run_txn(1'b0, 10'h3FB, 25'h0800000, 2'b00, 32'h00000000, 4'b0011, 4, 0, "unf");
      run_txn(1'b0, 10'd0,   25'h0800000, 2'b00, 32'h00000000, 4'b0011, 4, 0, "exp0");
      run_txn(1'b0, 10'd1,   25'h0800000, 2'b00, 32'h00800000, 4'b0000, 4, 0, "exp1");
      run_txn(1'b1, 10'd127, 25'h0000000, 2'b00, 32'h80000000, 4'b1000, 2, 3, "zero");
      run_txn(1'b0, 10'd127, 25'h0400001, 2'b11, 32'h3F000003, 4'b0001, 4, 0, "lz2_guard");
      run_txn(1'b0, 10'd127, 25'h0800001, 2'b10, 32'h3F800002, 4'b0001, 4, 0, "rne_up");
      run_txn(1'b0, 10'd127, 25'h0800000, 2'b10, 32'h3F800000, 4'b0001, 4, 0, "rne_even");
      run_txn(1'b0, 10'd127, 25'h1000001, 2'b00, 32'h40000000, 4'b0001, 4, 0, "rshift_g");

      // Reset while the transaction sits in SHIFT.
      @(negedge clk);
      in_valid = 1'b1;
      in_sign  = 1'b0;
      in_exp   = 10'd127;
      in_mant  = 25'h0800000;
      in_gs    = 2'b00;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_after_in_ready", 32'(in_ready), 32'd1);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      chk("midrst_no_output", 32'(seen), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
